itch5_msg_tx: RTL
=================

# itch5_msg_tx

Serializes one complete ITCH 5.0 message, presented in parallel, into a stream of 64-bit MoldUDP64 payload beats with start/last/keep framing. It is the transmit-side counterpart of the ITCH message accumulator. It sits between the message-generation logic (or test-vector source) and the MoldUDP64 payload path, and drives the `mold_v`/`mold_start`/`mold_data` stream that the receiver consumes. Supports output backpressure and back-to-back messages with no idle beat between them.

## Interface
Parameters:
- `AXI_DATA_W`, 64, beat width in bits
- `AXI_KEEP_W`, `AXI_DATA_W/8`, byte-enable width
- `LEN`, 8, bits per byte
- `MSG_MAX_B`, 50, maximum ITCH message length in bytes
- `CNT_MAX`, 7, maximum beats per message, equal to ceil(50*8/64)
- `MAX_W`, `CNT_MAX*AXI_DATA_W` (448), width of the parallel message bus
- `LEN_W`, 6, width of the byte-length field

Ports:
- `clk`, in, 1, clock
- `nreset`, in, 1, reset; one clock; reset is synchronous and active-high
- `msg_v_i`, in, 1, a message is offered on `msg_data_i`/`msg_len_i`
- `msg_ready_o`, out, 1, the block accepts the message this cycle
- `msg_data_i`, in, `MAX_W`, message bytes; byte n is at [8n+7:8n], so beat k is [64k+63:64k]
- `msg_len_i`, in, `LEN_W`, message length in bytes; legal range 1..50
- `mold_v_o`, out, 1, the beat is valid
- `mold_ready_i`, in, 1, downstream accepts the beat
- `mold_start_o`, out, 1, the beat is the first beat of a message
- `mold_last_o`, out, 1, the beat is the last beat of a message
- `mold_data_o`, out, `AXI_DATA_W`, beat payload
- `mold_keep_o`, out, `AXI_KEEP_W`, byte enables, bit n qualifies byte n
- `err_o`, out, 1, single-cycle pulse when a message with an illegal length is accepted

## Operation
- The FSM has two states: IDLE and SEND. The block resets into IDLE.
- Accept condition: `msg_v_i & msg_ready_o`. On accept, the block registers `msg_data_i` into the message buffer.
  - It stores `nbeats = (msg_len_i + 7) >> 3`, a 3-bit value in 1..7.
  - It stores `last_keep`: all-ones if `msg_len_i[2:0]==0`, otherwise `(1<<msg_len_i[2:0])-1`.
  - It clears the beat counter to 0.
- `msg_ready_o` = `~nreset & (IDLE | (SEND & mold_last_o & mold_ready_i))`.
- SEND state outputs:
  - `mold_v_o` = 1.
  - `mold_data_o` = buffer beat[cnt], with bytes where keep=0 forced to 0.
  - `mold_start_o` = (cnt==0).
  - `mold_last_o` = (cnt==nbeats-1).
  - `mold_keep_o` = all-ones, or `last_keep` on the last beat.
- Beat transfer condition: `mold_v_o & mold_ready_i`.
  - Not last beat: cnt is incremented.
  - Last beat with a new accept in the same cycle: the FSM stays in SEND and cnt is reloaded to 0.
  - Last beat with no accept: the FSM goes to IDLE.
- Backpressure: while `mold_v_o & ~mold_ready_i`, all `mold_*` outputs, cnt and the buffer hold stable.
- Illegal length (0 or >50):
  - The message is still accepted.
  - `err_o` pulses in the following cycle.
  - No beats are emitted, and the FSM goes to or stays in IDLE.
- cnt never wraps, because it is bounded by nbeats ≤ 7.
- Reset mid-message:
  - The message is dropped and the FSM returns to IDLE.
  - There is no resumption and no partial `mold_last_o`.
- IDLE outputs: `mold_v_o`=0, `mold_start_o`=0, `mold_last_o`=0, `mold_data_o`=0, `mold_keep_o`=0.

## Timing
- Reset values:
  - `msg_ready_o`=0 while `nreset`=1.
  - In the first cycle after reset deasserts, `msg_ready_o`=1.
  - All `mold_*` outputs = 0 and `err_o` = 0.
- Latency: a message accepted in cycle t shows its first beat in cycle t+1.
- With `mold_ready_i` held at 1, an N-beat message occupies cycles t+1 through t+N.
- Throughput: back-to-back messages leave no gap, so the start beat of the next message directly follows the last beat of the previous one.
- `msg_ready_o` depends combinationally on `mold_ready_i`. All other outputs come from registered state only.

## Test plan
- Length 8, data 0x0123456789ABCDEF, ready=1 -> one beat at t+1 with start=1, last=1, keep=0xFF, data=0x0123456789ABCDEF.
- Length 36 (Add Order) -> 5 beats, start on beat 0, last on beat 4, keep on beat 4 = 0x0F, bytes 36..39 = 0, `msg_ready_o` low during beats 0..3.
- Length 36 with `mold_ready_i` low for 3 cycles during beat 2 -> beat 2 data, keep, start and last held identical for 4 cycles, then beats 3..4 follow; total 5 transfers.
- Length 50 followed immediately by length 11 -> 7 beats with last keep=0x03, then with no gap 2 beats with start on the first and last keep=0x07.
- Length 0, then length 51 -> each accepted, `err_o` pulses one cycle after each, `mold_v_o` stays 0.
- `nreset` asserted during beat 3 of a 7-beat message -> the next cycle shows all `mold_*` outputs = 0 and `msg_ready_o`=0. After release, a new length-8 message is emitted with start=1.

Source files
------------

// File: rtl/itch5_msg_tx.sv
// ITCH 5.0 message serializer: takes one whole message in parallel and emits
// it as 64-bit MoldUDP64 payload beats with start/last/keep framing.
module itch5_msg_tx #(
   parameter int AXI_DATA_W = 64,
   parameter int AXI_KEEP_W = AXI_DATA_W/8,
   parameter int LEN        = 8,
   parameter int MSG_MAX_B  = 50,
   parameter int CNT_MAX    = 7,
   parameter int MAX_W      = CNT_MAX*AXI_DATA_W,
   parameter int LEN_W      = 6
)(
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  msg_v_i,
   output logic                  msg_ready_o,
   input  logic [MAX_W-1:0]      msg_data_i,
   input  logic [LEN_W-1:0]      msg_len_i,
   output logic                  mold_v_o,
   input  logic                  mold_ready_i,
   output logic                  mold_start_o,
   output logic                  mold_last_o,
   output logic [AXI_DATA_W-1:0] mold_data_o,
   output logic [AXI_KEEP_W-1:0] mold_keep_o,
   output logic                  err_o
);
   localparam int CNT_W = $clog2(CNT_MAX+1);
   localparam int KSH_W = $clog2(AXI_KEEP_W);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   typedef struct packed {
      logic [CNT_W-1:0]      nbeats;
      logic [AXI_KEEP_W-1:0] last_keep;
   } msg_desc_t;

   state_t                                state, state_nxt;
   logic [CNT_MAX-1:0][AXI_DATA_W-1:0]    msg_buf;
   msg_desc_t                             desc, desc_in;
   logic [CNT_W-1:0]                      cnt;
   logic                                  err_q;
   logic                                  accept, beat_xfer, len_ok, is_last;
   logic [LEN_W:0]                        len_rnd;
   logic [KSH_W-1:0]                      tail;
   logic [AXI_DATA_W-1:0]                 beat;

   // Length decode for the incoming message
   assign len_rnd = {1'b0, msg_len_i} + (LEN_W+1)'(AXI_KEEP_W-1);
   assign tail    = msg_len_i[KSH_W-1:0];
   assign len_ok  = (msg_len_i != '0) && (msg_len_i <= LEN_W'(MSG_MAX_B));
   assign desc_in.nbeats    = len_rnd[KSH_W +: CNT_W];
   assign desc_in.last_keep = (tail == '0) ? '1 : ~({AXI_KEEP_W{1'b1}} << tail);

   assign is_last     = (state == SEND) && (cnt == desc.nbeats - CNT_W'(1));
   assign msg_ready_o = ~nreset & ((state == IDLE) | (is_last & mold_ready_i));
   assign accept      = msg_v_i & msg_ready_o;
   assign beat_xfer   = mold_v_o & mold_ready_i;

   always_ff @(posedge clk) begin
      if (nreset) begin
         state <= IDLE;
         cnt   <= '0;
         err_q <= 1'b0;
         desc  <= '0;
      end else begin
         state <= state_nxt;
         err_q <= accept & ~len_ok;
         if (accept) begin
            msg_buf <= msg_data_i;
            desc    <= desc_in;
            cnt     <= '0;
         end else if (beat_xfer && !is_last) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // A last beat paired with a fresh legal accept keeps us in SEND: no gap
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept && len_ok) state_nxt = SEND;
         SEND: if (beat_xfer && is_last) state_nxt = (accept && len_ok) ? SEND : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign beat         = msg_buf[cnt];
   assign mold_v_o     = (state == SEND);
   assign mold_start_o = (state == SEND) && (cnt == '0);
   assign mold_last_o  = is_last;
   assign mold_keep_o  = (state != SEND) ? '0 : (is_last ? desc.last_keep : '1);
   assign err_o        = err_q;

   // Bytes beyond the message length never leave the block
   for (genvar b = 0; b < AXI_KEEP_W; b++) begin : g_lane
      assign mold_data_o[b*LEN +: LEN] = mold_keep_o[b] ? beat[b*LEN +: LEN] : '0;
   end

endmodule
